// File: rtl/mux_8bit_reg.sv
// 2:1 word multiplexer with a combinational output Y and a registered, valid-qualified copy Y_q.
// Optional registered even-parity output is enabled by defining MUX_8BIT_PARITY_EN.
module mux_8bit_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             select,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             out_valid
`ifdef MUX_8BIT_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] y_mux;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;

  // Bitwise steering so Y tracks A, B and select with no clock dependence.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux_bit
      assign y_mux[gi] = select ? B[gi] : A[gi];
    end
  endgenerate

  assign Y = y_mux;

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (in_valid) begin
      data_d  = y_mux;
      valid_d = 1'b1;
    end
  end

  // Reset has priority, so an X on select can never reach the register while rst=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign Y_q       = data_q;
  assign out_valid = valid_q;

`ifdef MUX_8BIT_PARITY_EN
  logic parity_q;
  logic parity_d;

  always_comb begin
    parity_d = parity_q;
    if (in_valid) begin
      parity_d = ^y_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_8bit_reg.sv
// Scoreboard bench for mux_8bit_reg: stimulus pushes expected captures, a monitor pops on out_valid.
// Define MUX_8BIT_PARITY_EN to also exercise the parity output.
`timescale 1ns/1ps
module tb_mux_8bit_reg;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic       select;
  logic       in_valid;
  logic [7:0] Y;
  logic [7:0] Y_q;
  logic       out_valid;
`ifdef MUX_8BIT_PARITY_EN
  logic       parity;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  mux_8bit_reg #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .select   (select),
    .in_valid (in_valid),
    .Y        (Y),
    .Y_q      (Y_q),
    .out_valid(out_valid)
`ifdef MUX_8BIT_PARITY_EN
    ,
    .parity   (parity)
`endif
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // One clock of stimulus; a capture is predicted only when rst=0 and in_valid=1.
  task automatic cyc(input logic r, input logic iv, input logic [7:0] a,
                     input logic [7:0] b, input logic s, input logic [7:0] exp_word);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = iv;
    A        = a;
    B        = b;
    select   = s;
    if (!r && iv) begin
      e.data = exp_word;
      e.par  = ^exp_word;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: rst/in_valid sampled at the active edge decide what the next negedge must show.
  logic       started;
  logic       rst_prev;
  logic       iv_prev;
  logic [7:0] hold_data;
  logic       hold_par;

  initial begin
    started   = 1'b0;
    hold_data = 8'd0;
    hold_par  = 1'b0;
    rst_prev  = 1'b1;
    iv_prev   = 1'b0;
    forever begin
      @(posedge clk);
      rst_prev = rst;
      iv_prev  = in_valid;
      started  = 1'b1;
      @(negedge clk);
      if (rst_prev) begin
        hold_data = 8'd0;
        hold_par  = 1'b0;
      end
      check("out_valid", {7'd0, out_valid}, {7'd0, !rst_prev && iv_prev});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_capture: got Y_q %0d expected no output", Y_q);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          hold_data = e.data;
          hold_par  = e.par;
          check("Y_q capture", Y_q, e.data);
`ifdef MUX_8BIT_PARITY_EN
          check("parity capture", {7'd0, parity}, {7'd0, e.par});
`endif
        end
      end else begin
        check(rst_prev ? "Y_q reset" : "Y_q hold", Y_q, hold_data);
`ifdef MUX_8BIT_PARITY_EN
        check(rst_prev ? "parity reset" : "parity hold", {7'd0, parity}, {7'd0, hold_par});
`endif
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    clk_en   = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;

    // Combinational path with the clock still stopped.
    A = 8'd216; B = 8'd20;  select = 1'b1; #1 check("comb Y sel1", Y, 8'd20);
    A = 8'd63;  B = 8'd202; select = 1'b0; #1 check("comb Y sel0", Y, 8'd63);
    A = 8'd231; B = 8'd185; select = 1'b1; #1 check("comb Y sel1", Y, 8'd185);
    A = 8'd229; B = 8'd84;  select = 1'b0; #1 check("comb Y sel0", Y, 8'd229);
    select = 1'b1; #1 check("comb Y toggle", Y, 8'd84);

    clk_en = 1'b1;
    cyc(1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 8'd0);
    cyc(1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 8'd0);
    cyc(1'b0, 1'b1, 8'd63,  8'd202, 1'b0, 8'd63);
    cyc(1'b0, 1'b1, 8'd63,  8'd202, 1'b1, 8'd202);
    cyc(1'b0, 1'b0, 8'd1,   8'd2,   1'b0, 8'd0);
    #1 check("comb Y mid", Y, 8'd1);
    select = 1'b1;
    #1 check("comb Y mid toggle", Y, 8'd2);
    cyc(1'b0, 1'b0, 8'd3,   8'd4,   1'b1, 8'd0);
    // Back-to-back captures, including the parity vectors.
    cyc(1'b0, 1'b1, 8'hD8,  8'h00,  1'b0, 8'hD8);
    cyc(1'b0, 1'b1, 8'hFF,  8'h14,  1'b1, 8'h14);
    cyc(1'b0, 1'b1, 8'hE5,  8'h33,  1'b0, 8'hE5);
    cyc(1'b0, 1'b1, 8'h80,  8'h7F,  1'b1, 8'h7F);
    // Reset wins over in_valid; the presented word is dropped.
    cyc(1'b1, 1'b1, 8'd255, 8'd0,   1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd9,   8'd9,   1'b0, 8'd0);
    cyc(1'b0, 1'b1, 8'd0,   8'd170, 1'b1, 8'd170);
    cyc(1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0,   8'd0,   1'b0, 8'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000ns");
    $fatal(1);
  end

endmodule
